// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Single-cycle RV32I integer ALU execution unit for the out-of-order core.
//   One issued ALU micro-op plus its operand values is accepted per cycle.
//   The result is computed combinationally and captured, together with its
//   completion tags, in a one-entry output slot. The slot is held until the
//   CDB arbiter grants writeback.
//
//   The package alu_exec_pkg carries the shared tag widths, the op and
//   source-select encodings and the reservation-station uop layout.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   synchronous active-high reset
//   req_valid   in   issue request valid
//   req_ready   out  unit can take a request this cycle
//   req_uop     in   issued micro-op (rs_uop_t)
//   rs1_val     in   source-1 register value
//   rs2_val     in   source-2 register value
//   wb_valid    out  result broadcast this cycle
//   wb_ready    in   writeback grant from the CDB arbiter
//   wb_pc       out  pc of the completing uop
//   wb_uses_rd  out  uop writes a destination register
//   wb_rob_idx  out  ROB entry of the completing uop
//   wb_prd_new  out  destination physical register
//   wb_epoch    out  epoch tag, passed through unchanged
//   wb_data     out  32-bit result
// -----------------------------------------------------------------------------

package alu_exec_pkg;

    localparam int ROB_W  = 5;
    localparam int PHYS_W = 6;

    typedef enum logic [1:0] {
        UC_ALU = 2'd0,
        UC_BR  = 2'd1,
        UC_MEM = 2'd2,
        UC_MUL = 2'd3
    } uop_class_e;

    // Immediate forms share the register-form op code. They differ only in
    // src2_select (SRC_IMM).
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_LUI   = 4'd10,
        OP_AUIPC = 4'd11
    } alu_op_e;

    // One select encoding serves both operand ports. A select that does not
    // apply to a port (e.g. SRC_IMM on src1) yields zero for that port.
    typedef enum logic [2:0] {
        SRC_RS1  = 3'd0,
        SRC_RS2  = 3'd1,
        SRC_PC   = 3'd2,
        SRC_IMM  = 3'd3,
        SRC_ZERO = 3'd4
    } src_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        uop_class_e  uop_class;
        alu_op_e     op;
        src_sel_e    src1_select;
        src_sel_e    src2_select;
        logic [31:0] imm;
        logic        uses_rd;
    } uop_bundle_t;

    typedef struct packed {
        uop_bundle_t       bundle;
        logic [ROB_W-1:0]  rob_idx;
        logic [1:0]        epoch;
        logic [PHYS_W-1:0] prd_new;
    } rs_uop_t;

endpackage

module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  rs_uop_t           req_uop,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       rs2_val,

    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_pc,
    output logic              wb_uses_rd,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [PHYS_W-1:0] wb_prd_new,
    output logic [1:0]        wb_epoch,
    output logic [31:0]       wb_data
);

    // -------------------------------------------------------------------------
    // Output slot
    // -------------------------------------------------------------------------
    logic              r_full;
    logic [31:0]       r_pc;
    logic              r_uses_rd;
    logic [ROB_W-1:0]  r_rob_idx;
    logic [PHYS_W-1:0] r_prd_new;
    logic [1:0]        r_epoch;
    logic [31:0]       r_data;

    logic              w_fire;
    logic              w_drain;
    logic [31:0]       w_op_a;
    logic [31:0]       w_op_b;
    logic [4:0]        w_shamt;
    logic [31:0]       w_result;

    // The class field is only consumed by the issue logic upstream.
    logic              w_unused_class;
    assign w_unused_class = ^req_uop.bundle.uop_class;

    // -------------------------------------------------------------------------
    // Handshake
    //   A draining slot frees the entry in the same cycle, so a new uop can
    //   overwrite it. This gives full throughput under a steady grant.
    // -------------------------------------------------------------------------
    assign req_ready = !r_full || wb_ready;
    assign w_fire    = req_valid && req_ready;
    assign w_drain   = r_full && wb_ready;

    // The grant qualifies the broadcast. A held result is never shown as
    // valid without it.
    assign wb_valid  = w_drain;

    // -------------------------------------------------------------------------
    // Operand selection
    // -------------------------------------------------------------------------
    always_comb begin
        w_op_a = 32'd0;
        case (req_uop.bundle.src1_select)
            SRC_RS1: w_op_a = rs1_val;
            SRC_PC:  w_op_a = req_uop.bundle.pc;
            default: w_op_a = 32'd0;
        endcase
    end

    always_comb begin
        w_op_b = 32'd0;
        case (req_uop.bundle.src2_select)
            SRC_RS2: w_op_b = rs2_val;
            SRC_IMM: w_op_b = req_uop.bundle.imm;
            default: w_op_b = 32'd0;
        endcase
    end

    assign w_shamt = w_op_b[4:0];

    // -------------------------------------------------------------------------
    // Result
    //   LUI and AUIPC read pc/imm directly, so their result does not depend
    //   on how the selects happen to be set.
    // -------------------------------------------------------------------------
    always_comb begin
        w_result = 32'd0;
        case (req_uop.bundle.op)
            OP_ADD:   w_result = w_op_a + w_op_b;
            OP_SUB:   w_result = w_op_a - w_op_b;
            OP_AND:   w_result = w_op_a & w_op_b;
            OP_OR:    w_result = w_op_a | w_op_b;
            OP_XOR:   w_result = w_op_a ^ w_op_b;
            OP_SLL:   w_result = w_op_a << w_shamt;
            OP_SRL:   w_result = w_op_a >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(w_op_a) >>> w_shamt);
            OP_SLT:   w_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            OP_SLTU:  w_result = {31'd0, w_op_a < w_op_b};
            OP_LUI:   w_result = req_uop.bundle.imm;
            OP_AUIPC: w_result = req_uop.bundle.pc + req_uop.bundle.imm;
            // Unknown encodings still complete, with a zero result.
            default:  w_result = 32'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Slot register
    //   Payload stays untouched while the grant is withheld. On a drain
    //   without a refill only the full flag clears.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_pc      <= 32'd0;
            r_uses_rd <= 1'b0;
            r_rob_idx <= '0;
            r_prd_new <= '0;
            r_epoch   <= 2'd0;
            r_data    <= 32'd0;
        end else if (w_fire) begin
            r_full    <= 1'b1;
            r_pc      <= req_uop.bundle.pc;
            r_uses_rd <= req_uop.bundle.uses_rd;
            r_rob_idx <= req_uop.rob_idx;
            r_prd_new <= req_uop.prd_new;
            r_epoch   <= req_uop.epoch;
            r_data    <= w_result;
        end else if (w_drain) begin
            r_full    <= 1'b0;
        end
    end

    assign wb_pc      = r_pc;
    assign wb_uses_rd = r_uses_rd;
    assign wb_rob_idx = r_rob_idx;
    assign wb_prd_new = r_prd_new;
    assign wb_epoch   = r_epoch;
    assign wb_data    = r_data;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    rs_uop_t           req_uop;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_pc;
    logic              wb_uses_rd;
    logic [ROB_W-1:0]  wb_rob_idx;
    logic [PHYS_W-1:0] wb_prd_new;
    logic [1:0]        wb_epoch;
    logic [31:0]       wb_data;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_uop    (req_uop),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_pc      (wb_pc),
        .wb_uses_rd (wb_uses_rd),
        .wb_rob_idx (wb_rob_idx),
        .wb_prd_new (wb_prd_new),
        .wb_epoch   (wb_epoch),
        .wb_data    (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        alu_op_e     op;
        src_sel_e    s1;
        src_sel_e    s2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        uses_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_uop(input alu_op_e op, input src_sel_e s1, input src_sel_e s2,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b, input logic urd,
                           input logic [4:0] rob, input logic [5:0] prd, input logic [1:0] ep);
        req_uop                    = '0;
        req_uop.bundle.pc          = pc;
        req_uop.bundle.uop_class   = UC_ALU;
        req_uop.bundle.op          = op;
        req_uop.bundle.src1_select = s1;
        req_uop.bundle.src2_select = s2;
        req_uop.bundle.imm         = imm;
        req_uop.bundle.uses_rd     = urd;
        req_uop.rob_idx            = rob;
        req_uop.prd_new            = prd;
        req_uop.epoch              = ep;
        rs1_val                    = a;
        rs2_val                    = b;
    endtask

    initial begin
        logic [4:0] rob;
        logic [5:0] prd;
        logic [1:0] ep;
        logic [3:0] bad_op;

        bad_op = 4'hF;
        vecs[0]  = '{"add",      OP_ADD,  SRC_RS1,  SRC_RS2, 32'h0000_0400, 32'h0,         32'd100,       32'd50,        1'b1, 32'd150};
        vecs[1]  = '{"andi",     OP_AND,  SRC_RS1,  SRC_IMM, 32'h0000_0404, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_00FF};
        vecs[2]  = '{"ori",      OP_OR,   SRC_RS1,  SRC_IMM, 32'h0000_0408, 32'h0000_00FF, 32'h1234_5678, 32'h0,         1'b1, 32'h1234_56FF};
        vecs[3]  = '{"xori",     OP_XOR,  SRC_RS1,  SRC_IMM, 32'h0000_040C, 32'h0000_00FF, 32'h0000_00FF, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{"sra",      OP_SRA,  SRC_RS1,  SRC_RS2, 32'h0000_0410, 32'h0,         32'h8000_0000, 32'd4,         1'b1, 32'hF800_0000};
        vecs[5]  = '{"srl",      OP_SRL,  SRC_RS1,  SRC_RS2, 32'h0000_0414, 32'h0,         32'h8000_0000, 32'd4,         1'b1, 32'h0800_0000};
        vecs[6]  = '{"slli31",   OP_SLL,  SRC_RS1,  SRC_IMM, 32'h0000_0418, 32'd31,        32'd1,         32'h0,         1'b1, 32'h8000_0000};
        vecs[7]  = '{"slli0",    OP_SLL,  SRC_RS1,  SRC_IMM, 32'h0000_041C, 32'd0,         32'hDEAD_BEEF, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{"slt_t",    OP_SLT,  SRC_RS1,  SRC_RS2, 32'h0000_0420, 32'h0,         32'hFFFF_FFF0, 32'd10,        1'b1, 32'd1};
        vecs[9]  = '{"slt_f",    OP_SLT,  SRC_RS1,  SRC_RS2, 32'h0000_0424, 32'h0,         32'd10,        32'hFFFF_FFF0, 1'b1, 32'd0};
        vecs[10] = '{"sltu",     OP_SLTU, SRC_RS1,  SRC_RS2, 32'h0000_0428, 32'h0,         32'd10,        32'hFFFF_FFFF, 1'b1, 32'd1};
        vecs[11] = '{"sltiu",    OP_SLTU, SRC_RS1,  SRC_IMM, 32'h0000_042C, 32'd10,        32'hFFFF_FFFF, 32'h0,         1'b1, 32'd0};
        vecs[12] = '{"lui",      OP_LUI,  SRC_RS1,  SRC_RS2, 32'h0000_0430, 32'h1234_5000, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h1234_5000};
        vecs[13] = '{"auipc",    OP_AUIPC,SRC_ZERO, SRC_RS2, 32'h0000_1054, 32'h0000_1000, 32'h3333_3333, 32'h4444_4444, 1'b1, 32'h0000_2054};
        vecs[14] = '{"add_wrap", OP_ADD,  SRC_RS1,  SRC_RS2, 32'h0000_0438, 32'h0,         32'hFFFF_FFFF, 32'd1,         1'b1, 32'h0};
        vecs[15] = '{"add_pcimm",OP_ADD,  SRC_PC,   SRC_IMM, 32'h0000_0100, 32'd4,         32'd999,       32'd999,       1'b1, 32'h0000_0104};
        vecs[16] = '{"sra_b40",  OP_SRA,  SRC_RS1,  SRC_RS2, 32'h0000_0440, 32'h0,         32'h8000_0000, 32'h0000_0024, 1'b1, 32'hF800_0000};
        vecs[17] = '{"sub_neg",  OP_SUB,  SRC_RS1,  SRC_RS2, 32'h0000_0444, 32'h0,         32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE};
        vecs[18] = '{"zero_a",   OP_ADD,  SRC_ZERO, SRC_RS2, 32'h0000_0448, 32'h0,         32'd100,       32'd7,         1'b1, 32'd7};
        vecs[19] = '{"bad_op",   alu_op_e'(bad_op), SRC_RS1, SRC_RS2, 32'h0000_044C, 32'h0, 32'd5,        32'd6,         1'b1, 32'd0};

        rst = 1'b1; req_valid = 1'b0; wb_ready = 1'b1;
        set_uop(OP_ADD, SRC_RS1, SRC_RS2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_payload", {wb_pc, wb_uses_rd, wb_rob_idx, wb_prd_new, wb_epoch, wb_data[17:0]}, 64'd0);
        chk("rst_data", {32'd0, wb_data}, 64'd0);

        // Table of single ops, each followed by a free grant
        for (int i = 0; i < 20; i++) begin
            rob = 5'(i + 3);
            prd = 6'(i + 20);
            ep  = 2'(i);
            @(negedge clk);
            set_uop(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].pc, vecs[i].imm,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rd, rob, prd, ep);
            req_valid = 1'b1;
            wb_ready  = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            chk({vecs[i].name, "_data"}, {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, vecs[i].exp});
            chk({vecs[i].name, "_tags"}, {18'd0, wb_pc, wb_uses_rd, wb_rob_idx, wb_prd_new, wb_epoch},
                {18'd0, vecs[i].pc, vecs[i].uses_rd, rob, prd, ep});
        end
        @(posedge clk);
        #1 chk("idle_after_table", {63'd0, wb_valid}, 64'd0);

        // Backpressure: result held without grant
        @(negedge clk);
        wb_ready = 1'b0;
        set_uop(OP_ADD, SRC_RS1, SRC_RS2, 32'h0000_0800, 32'h0, 32'd10, 32'd20, 1'b1, 5'd9, 6'd33, 2'd2);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("bp_hold_valid", {63'd0, wb_valid}, 64'd0);
            chk("bp_hold_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_hold_data", {32'd0, wb_data}, {32'd0, 32'd30});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        wb_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'd30});
        chk("bp_release_tags", {wb_rob_idx, wb_prd_new, wb_epoch}, {51'd0, 5'd9, 6'd33, 2'd2});
        @(posedge clk);
        #1 chk("bp_drained", {63'd0, wb_valid}, 64'd0);

        // Back-to-back: ADD 1+2 then SUB 10-3
        @(negedge clk);
        set_uop(OP_ADD, SRC_RS1, SRC_RS2, 32'h0000_0900, 32'h0, 32'd1, 32'd2, 1'b1, 5'd1, 6'd1, 2'd1);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        set_uop(OP_SUB, SRC_RS1, SRC_RS2, 32'h0000_0904, 32'h0, 32'd10, 32'd3, 1'b1, 5'd2, 6'd2, 2'd1);
        chk("b2b_first", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'd3});
        chk("b2b_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("b2b_second", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'd7});
        chk("b2b_second_rob", {59'd0, wb_rob_idx}, 64'd2);
        @(posedge clk);
        #1 chk("b2b_idle", {63'd0, wb_valid}, 64'd0);

        // Drain and refill in one cycle while previously held
        @(negedge clk);
        wb_ready = 1'b0;
        set_uop(OP_ADD, SRC_RS1, SRC_RS2, 32'h0, 32'h0, 32'd40, 32'd2, 1'b1, 5'd4, 6'd4, 2'd0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        set_uop(OP_XOR, SRC_RS1, SRC_RS2, 32'h0, 32'h0, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, 5'd5, 6'd5, 2'd0);
        @(posedge clk);
        #1 chk("ovw_blocked", {32'd0, wb_data}, {32'd0, 32'd42});
        @(negedge clk);
        wb_ready = 1'b1;
        #1 chk("ovw_first", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'd42});
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("ovw_second", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'h0F0F_F0F0});
        @(posedge clk);

        // Reset discards a held result
        @(negedge clk);
        wb_ready = 1'b0;
        set_uop(OP_ADD, SRC_RS1, SRC_RS2, 32'h0000_0A00, 32'h0, 32'd5, 32'd5, 1'b1, 5'd7, 6'd7, 2'd3);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, wb_valid}, 64'd0);
        chk("midrst_data", {32'd0, wb_data}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 chk("midrst_no_bcast", {63'd0, wb_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
